// File: rtl/sha2_pkg.sv
// sha2_pkg: shared SHA-2 definitions for the round-constant streamer.
// Contents: state enum, round-index width, round counts per word width,
// K256 (64 x 32-bit) and K512 (80 x 64-bit) round-constant tables.
package sha2_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } seq_state_e;

  localparam int unsigned ROUND_IDX_W = 7;
  localparam int unsigned ROUNDS_256  = 64;
  localparam int unsigned ROUNDS_512  = 80;

  // Number of rounds for a given word width (64-bit words -> SHA-384/512).
  function automatic int unsigned rounds_for(input int unsigned word_w);
    return (word_w == 64) ? ROUNDS_512 : ROUNDS_256;
  endfunction

  localparam logic [31:0] K256 [ROUNDS_256] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [63:0] K512 [ROUNDS_512] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

endpackage

// File: rtl/sha2_k_rom.sv
// sha2_k_rom: combinational K-table lookup for the selected word width.
// Ports:
//   idx_i  round index (7 bits)
//   k_o    K[idx_i] for the SHA-256 (WORD_W=32) or SHA-512 (WORD_W=64) table;
//          zero for an index past the last round
module sha2_k_rom
  import sha2_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic [ROUND_IDX_W-1:0] idx_i,
  output logic [WORD_W-1:0]      k_o
);

  generate
    if (WORD_W == 64) begin : g_k512
      // 80-entry table, 7-bit index covers it directly
      always_comb begin
        k_o = '0;
        if (idx_i < ROUND_IDX_W'(ROUNDS_512)) begin
          k_o = WORD_W'(K512[idx_i]);
        end
      end
    end else begin : g_k256
      // 64-entry table; bit 6 only participates in the range check
      always_comb begin
        k_o = '0;
        if (idx_i < ROUND_IDX_W'(ROUNDS_256)) begin
          k_o = WORD_W'(K256[idx_i[5:0]]);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/sha2_k_sequencer.sv
// sha2_k_sequencer: streams the SHA-2 round constants K[0..ROUNDS-1] over a
// valid/ready interface, one constant per accepted beat.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           begin a pass (honoured only when idle, abort low)
//   abort           end the current pass without a done pulse
//   k_ready         consumer accepts the presented constant
//   k_valid         k_value/k_round/k_last valid
//   k_value         K[k_round], zero while k_valid is low
//   k_round         round index of the presented constant
//   k_last          presented constant is the final round
//   busy            pass in progress
//   done            one-cycle pulse after the final constant is accepted
module sha2_k_sequencer
  import sha2_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   k_ready,
  output logic                   k_valid,
  output logic [WORD_W-1:0]      k_value,
  output logic [ROUND_IDX_W-1:0] k_round,
  output logic                   k_last,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned ROUNDS = rounds_for(WORD_W);
  localparam logic [ROUND_IDX_W-1:0] LAST_RND = ROUND_IDX_W'(ROUNDS - 1);

  generate
    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
      $error("sha2_k_sequencer: WORD_W must be 32 or 64");
    end
  endgenerate

  seq_state_e             state_q, state_d;
  logic [ROUND_IDX_W-1:0] cnt_q, cnt_d;
  logic                   k_valid_q, k_valid_d;
  logic [WORD_W-1:0]      k_value_q, k_value_d;
  logic [ROUND_IDX_W-1:0] k_round_q, k_round_d;
  logic                   k_last_q, k_last_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [WORD_W-1:0]      rom_k;
  logic                   handshake;

  // ROM is addressed by the next counter value so its output lands in the
  // output register in the same cycle the counter advances.
  sha2_k_rom #(
    .WORD_W(WORD_W)
  ) u_rom (
    .idx_i(cnt_d),
    .k_o  (rom_k)
  );

  assign handshake = k_valid_q & k_ready;

  // Next-state, counter and registered-output values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = STREAM;
          cnt_d   = '0;
        end
      end
      STREAM: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (handshake) begin
          if (cnt_q == LAST_RND) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + ROUND_IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A stall leaves state and counter unchanged, so these recompute to the
    // same values and the outputs stay bit-stable.
    k_valid_d = (state_d == STREAM);
    busy_d    = (state_d == STREAM);
    k_value_d = k_valid_d ? rom_k : '0;
    k_round_d = k_valid_d ? cnt_d : '0;
    k_last_d  = k_valid_d && (cnt_d == LAST_RND);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      k_valid_q <= 1'b0;
      k_value_q <= '0;
      k_round_q <= '0;
      k_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      k_valid_q <= k_valid_d;
      k_value_q <= k_value_d;
      k_round_q <= k_round_d;
      k_last_q  <= k_last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign k_valid = k_valid_q;
  assign k_value = k_value_q;
  assign k_round = k_round_q;
  assign k_last  = k_last_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_sha2_k_sequencer.sv
// Bench for sha2_k_sequencer: one 32-bit and one 64-bit instance. Expected
// constants come from the defining rule (fractional bits of the cube roots
// of the first primes), computed here by integer cube-root search.
module tb_sha2_k_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst32_n, start32, abort32, ready32;
  logic        valid32, last32, busy32, done32;
  logic [31:0] value32;
  logic [6:0]  round32;

  logic        rst64_n, start64, abort64, ready64;
  logic        valid64, last64, busy64, done64;
  logic [63:0] value64;
  logic [6:0]  round64;

  sha2_k_sequencer #(.WORD_W(32)) dut32 (
    .clk(clk), .rst_n(rst32_n), .start(start32), .abort(abort32),
    .k_ready(ready32), .k_valid(valid32), .k_value(value32),
    .k_round(round32), .k_last(last32), .busy(busy32), .done(done32)
  );

  sha2_k_sequencer #(.WORD_W(64)) dut64 (
    .clk(clk), .rst_n(rst64_n), .start(start64), .abort(abort64),
    .k_ready(ready64), .k_valid(valid64), .k_value(value64),
    .k_round(round64), .k_last(last64), .busy(busy64), .done(done64)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] kref32 [64];
  logic [63:0] kref64 [80];
  logic [63:0] cap32 [64];
  logic [63:0] cap64 [80];
  bit          caplast32 [64];
  bit          caplast64 [80];

  typedef struct {
    bit          w64;
    int          rnd;
    logic [63:0] k;
    bit          last;
  } vec_t;
  vec_t vecs [5];

  function automatic int nth_prime(input int n);
    int cnt = -1;
    for (int p = 2; p < 1000; p++) begin
      bit isp = 1'b1;
      for (int d = 2; d * d <= p; d++) if (p % d == 0) isp = 1'b0;
      if (isp) begin
        cnt++;
        if (cnt == n) return p;
      end
    end
    return 0;
  endfunction

  // floor(cbrt(p) * 2^ww) mod 2^ww via binary search on integers
  function automatic logic [63:0] cube_frac(input int p, input int ww);
    logic [255:0] target, lo, hi, mid;
    target = 256'(p) << (3 * ww);
    lo = '0;
    hi = 256'd1 << (ww + 3);
    while (hi - lo > 256'd1) begin
      mid = (lo + hi) >> 1;
      if (mid * mid * mid <= target) lo = mid;
      else hi = mid;
    end
    return (ww == 32) ? {32'd0, lo[31:0]} : lo[63:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet32(input string tag);
    check({tag, "_valid"}, 64'(valid32), 64'd0);
    check({tag, "_busy"},  64'(busy32),  64'd0);
    check({tag, "_value"}, 64'(value32), 64'd0);
    check({tag, "_round"}, 64'(round32), 64'd0);
    check({tag, "_last"},  64'(last32),  64'd0);
  endtask

  // Full pass at one beat per cycle; returns positioned on the done cycle
  task automatic run_full32();
    start32 = 1'b1;
    ready32 = 1'b1;
    tick();
    start32 = 1'b0;
    for (int r = 0; r < 64; r++) begin
      check("f32_valid", 64'(valid32), 64'd1);
      check("f32_busy",  64'(busy32),  64'd1);
      check("f32_round", 64'(round32), 64'(r));
      check("f32_value", 64'(value32), kref32[r]);
      check("f32_last",  64'(last32),  64'(r == 63));
      check("f32_done",  64'(done32),  64'd0);
      cap32[r]     = 64'(value32);
      caplast32[r] = last32;
      tick();
    end
    check("f32_done_pulse", 64'(done32), 64'd1);
    check_quiet32("f32_after");
  endtask

  task automatic run_full64();
    start64 = 1'b1;
    ready64 = 1'b1;
    tick();
    start64 = 1'b0;
    for (int r = 0; r < 80; r++) begin
      check("f64_valid", 64'(valid64), 64'd1);
      check("f64_round", 64'(round64), 64'(r));
      check("f64_value", value64, kref64[r]);
      check("f64_last",  64'(last64),  64'(r == 79));
      check("f64_done",  64'(done64),  64'd0);
      cap64[r]     = value64;
      caplast64[r] = last64;
      tick();
    end
    check("f64_done_pulse", 64'(done64),  64'd1);
    check("f64_after_valid", 64'(valid64), 64'd0);
    check("f64_after_value", value64, 64'd0);
    tick();
    check("f64_done_clear", 64'(done64), 64'd0);
  endtask

  // Random k_ready with stray start pulses while busy; model is a beat index
  task automatic run_random32();
    int          exp_idx = 0;
    int          idx;
    bit          stalled = 1'b0;
    bit          got_done = 1'b0;
    logic [31:0] prev_value = '0;
    logic [6:0]  prev_round = '0;
    start32 = 1'b1;
    ready32 = 1'b0;
    tick();
    start32 = 1'b0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (done32) begin
        got_done = 1'b1;
        break;
      end
      idx = (exp_idx > 63) ? 63 : exp_idx;
      check("rnd_valid", 64'(valid32), 64'd1);
      check("rnd_round", 64'(round32), 64'(exp_idx));
      check("rnd_value", 64'(value32), kref32[idx]);
      check("rnd_last",  64'(last32),  64'(exp_idx == 63));
      if (stalled) begin
        check("rnd_stall_value", 64'(value32), 64'(prev_value));
        check("rnd_stall_round", 64'(round32), 64'(prev_round));
      end
      prev_value = value32;
      prev_round = round32;
      ready32 = 1'($urandom_range(0, 1));
      start32 = ($urandom_range(0, 7) == 0);
      stalled = !ready32;
      if (ready32) exp_idx++;
      tick();
    end
    start32 = 1'b0;
    ready32 = 1'b0;
    check("rnd_done_seen", 64'(got_done), 64'd1);
    check("rnd_beats", 64'(exp_idx), 64'd64);
    check_quiet32("rnd_after");
    tick();
    check("rnd_done_clear", 64'(done32), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{w64: 1'b0, rnd: 0,  k: 64'h0000_0000_428a_2f98, last: 1'b0};
    vecs[1] = '{w64: 1'b0, rnd: 63, k: 64'h0000_0000_c671_78f2, last: 1'b1};
    vecs[2] = '{w64: 1'b1, rnd: 0,  k: 64'h428a_2f98_d728_ae22, last: 1'b0};
    vecs[3] = '{w64: 1'b1, rnd: 1,  k: 64'h7137_4491_23ef_65cd, last: 1'b0};
    vecs[4] = '{w64: 1'b1, rnd: 79, k: 64'h6c44_198c_4a47_5817, last: 1'b1};

    for (int i = 0; i < 64; i++) kref32[i] = cube_frac(nth_prime(i), 32);
    for (int i = 0; i < 80; i++) kref64[i] = cube_frac(nth_prime(i), 64);

    rst32_n = 1'b0; start32 = 1'b0; abort32 = 1'b0; ready32 = 1'b0;
    rst64_n = 1'b0; start64 = 1'b0; abort64 = 1'b0; ready64 = 1'b0;
    tick();
    tick();
    check_quiet32("reset");
    check("reset_done", 64'(done32), 64'd0);
    check("reset64_valid", 64'(valid64), 64'd0);
    check("reset64_value", value64, 64'd0);
    rst32_n = 1'b1;
    rst64_n = 1'b1;
    tick();

    // full-rate passes on both widths
    run_full32();
    tick();
    check("f32_done_clear", 64'(done32), 64'd0);
    run_full64();

    // spot vectors against the captured streams
    foreach (vecs[i]) begin
      check("vec_value", vecs[i].w64 ? cap64[vecs[i].rnd] : cap32[vecs[i].rnd], vecs[i].k);
      check("vec_last",  64'(vecs[i].w64 ? caplast64[vecs[i].rnd] : caplast32[vecs[i].rnd]),
            64'(vecs[i].last));
    end

    // random backpressure
    run_random32();

    // abort at round 10 while stalled
    start32 = 1'b1;
    ready32 = 1'b1;
    tick();
    start32 = 1'b0;
    for (int i = 0; i < 100 && round32 != 7'd10; i++) tick();
    ready32 = 1'b0;
    check("abort_round10", 64'(round32), 64'd10);
    tick();
    check("abort_stall_round", 64'(round32), 64'd10);
    check("abort_stall_value", 64'(value32), kref32[10]);
    abort32 = 1'b1;
    ready32 = 1'b1;
    tick();
    abort32 = 1'b0;
    check_quiet32("abort");
    check("abort_no_done", 64'(done32), 64'd0);
    tick();
    check("abort_no_done2", 64'(done32), 64'd0);
    start32 = 1'b1;
    tick();
    start32 = 1'b0;
    check("restart_valid", 64'(valid32), 64'd1);
    check("restart_round", 64'(round32), 64'd0);
    check("restart_value", 64'(value32), kref32[0]);

    // synchronous reset mid-pass at round 30
    for (int i = 0; i < 100 && round32 != 7'd30; i++) tick();
    check("rst_at_round30", 64'(round32), 64'd30);
    rst32_n = 1'b0;
    tick();
    check_quiet32("midrst");
    check("midrst_done", 64'(done32), 64'd0);
    rst32_n = 1'b1;
    ready32 = 1'b0;
    tick();
    check("midrst_stay_idle", 64'(valid32), 64'd0);
    check("midrst_no_done", 64'(done32), 64'd0);

    // start and abort together in idle, then abort alone
    start32 = 1'b1;
    abort32 = 1'b1;
    tick();
    start32 = 1'b0;
    check_quiet32("startabort");
    tick();
    abort32 = 1'b0;
    check("abort_idle_valid", 64'(valid32), 64'd0);
    check("abort_idle_done", 64'(done32), 64'd0);

    // back-to-back: start during the done cycle
    run_full32();
    start32 = 1'b1;
    tick();
    start32 = 1'b0;
    check("b2b_valid", 64'(valid32), 64'd1);
    check("b2b_busy",  64'(busy32),  64'd1);
    check("b2b_round", 64'(round32), 64'd0);
    check("b2b_value", 64'(value32), kref32[0]);
    check("b2b_done",  64'(done32),  64'd0);
    abort32 = 1'b1;
    tick();
    abort32 = 1'b0;
    check("b2b_abort_valid", 64'(valid32), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
